pc_seq_ctrl: RTL and testbench

- Next-PC sequencer for the 19-bit CPU. Drives pc_next into the program-counter register and takes that register's current value back on pc.
- Arbitrates between sequential fetch, branch, jump, call/return and halt requests.
- Owns an 8-deep hardware return-address stack (RAS) and a boot/run/halt state machine.
- pc_next is combinational from pc, the controls and the registered state. All stack and state updates happen on the clock edge.

---
 rtl/pc_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer: picks the next fetch address from sequential/branch/jump/call/return/halt requests.
// Latency: pc_next is combinational from pc, the controls and the registered state; RAS/state update at the edge.
// Backpressure: stall (or HALT) holds pc_next at pc with no stack or state change.
//
// Ports:
//   clk, rst           clock (rising edge); synchronous active-low reset
//   pc                 current program-counter register value
//   stall              hold the PC this cycle
//   halt_req, resume   enter HALT / leave HALT
//   br_taken/br_target conditional branch resolved taken and its target
//   jmp/jmp_target     unconditional jump; jmp_target is also the call target
//   call, ret          push pc+1 and go to jmp_target / pop the return stack
//   irq, iret          level interrupt request / interrupt return (PCSEQ_IRQ_EN only)
//   pc_next            next PC into the PC register
//   running            sequencer is in RUN
//   irq_ack            pulse in the cycle an interrupt is taken
//   ras_empty/full     return stack occupancy
//   ras_ovf/ras_unf    sticky overflow / underflow errors, cleared only by reset
//
// Build option: define PCSEQ_IRQ_EN to add interrupt entry (IRQ_VEC), epc and the
// interrupt mask. Without it irq/iret are ignored and irq_ack is tied low.

module pc_seq_ctrl #(
   parameter int unsigned       ADDR_W    = 19,
   parameter int unsigned       RAS_DEPTH = 8,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter logic [ADDR_W-1:0] IRQ_VEC   = 'h10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc,
   input  logic              stall,
   input  logic              halt_req,
   input  logic              resume,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              jmp,
   input  logic [ADDR_W-1:0] jmp_target,
   input  logic              call,
   input  logic              ret,
   input  logic              irq,
   input  logic              iret,
   output logic [ADDR_W-1:0] pc_next,
   output logic              running,
   output logic              irq_ack,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_ovf,
   output logic              ras_unf
);

   localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(RAS_DEPTH);
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t state, state_nxt;

   // Return stack: wr_ptr is the next free slot, the top of stack sits just
   // below it. Because the pointer wraps, a push into a full stack lands on
   // the oldest entry, which gives the circular-overwrite behaviour for free.
   logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  top_ptr;
   logic [CNT_W-1:0]  ras_cnt;
   logic [ADDR_W-1:0] ras_top;

   logic [ADDR_W-1:0] pc_inc;

   // Result of the low-priority rules (ret/call/jmp/br/sequential).
   logic [ADDR_W-1:0] low_pc;
   logic              low_push;
   logic              low_pop;
   logic              low_ovf;
   logic              low_unf;

   // Actions selected for this cycle.
   logic              push_en;
   logic              pop_en;
   logic              set_ovf;
   logic              set_unf;
   logic              irq_take;
   logic              iret_take;

   assign pc_inc    = pc + ADDR_ONE;
   assign top_ptr   = wr_ptr - PTR_ONE;
   assign ras_top   = ras_mem[top_ptr];
   assign ras_empty = (ras_cnt == '0);
   assign ras_full  = (ras_cnt == CNT_MAX);
   assign running   = (state == ST_RUN);

`ifdef PCSEQ_IRQ_EN
   logic [ADDR_W-1:0] epc;
   logic              irq_en;
`endif

   //------------------------------------------------------------------
   // Low-priority rules, evaluated independently so the interrupt path
   // can capture where execution would otherwise have gone.
   //------------------------------------------------------------------
   always_comb begin
      low_pc   = pc_inc;
      low_push = 1'b0;
      low_pop  = 1'b0;
      low_ovf  = 1'b0;
      low_unf  = 1'b0;
      if (ret) begin
         // ret beats call when both are raised; an empty stack falls
         // through to sequential fetch and records the underflow.
         if (ras_empty) begin
            low_unf = 1'b1;
         end else begin
            low_pc  = ras_top;
            low_pop = 1'b1;
         end
      end else if (call) begin
         low_pc   = jmp_target;
         low_push = 1'b1;
         low_ovf  = ras_full;
      end else if (jmp) begin
         low_pc = jmp_target;
      end else if (br_taken) begin
         low_pc = br_target;
      end
   end

   //------------------------------------------------------------------
   // Next-state / next-PC selection.
   //------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      pc_next   = pc;
      push_en   = 1'b0;
      pop_en    = 1'b0;
      set_ovf   = 1'b0;
      set_unf   = 1'b0;
      irq_take  = 1'b0;
      iret_take = 1'b0;

      if (!rst) begin
         state_nxt = ST_BOOT;
         pc_next   = RESET_VEC;
      end else begin
         case (state)
            ST_BOOT: begin
               pc_next   = RESET_VEC;
               state_nxt = ST_RUN;
            end

            ST_HALT: begin
               pc_next = pc;
               if (resume) begin
                  state_nxt = ST_RUN;
               end
            end

            ST_RUN: begin
               if (halt_req) begin
                  pc_next   = pc;
                  state_nxt = ST_HALT;
               end else if (stall) begin
                  pc_next = pc;
`ifdef PCSEQ_IRQ_EN
               end else if (irq && irq_en) begin
                  pc_next  = IRQ_VEC;
                  irq_take = 1'b1;
               end else if (iret) begin
                  pc_next   = epc;
                  iret_take = 1'b1;
`endif
               end else begin
                  pc_next = low_pc;
                  push_en = low_push;
                  pop_en  = low_pop;
                  set_ovf = low_ovf;
                  set_unf = low_unf;
               end
            end

            default: begin
               pc_next   = RESET_VEC;
               state_nxt = ST_BOOT;
            end
         endcase
      end
   end

   //------------------------------------------------------------------
   // State and stack bookkeeping.
   //------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= ST_BOOT;
         wr_ptr  <= '0;
         ras_cnt <= '0;
         ras_ovf <= 1'b0;
         ras_unf <= 1'b0;
      end else begin
         state <= state_nxt;

         if (push_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            // A push into a full stack replaces the oldest entry, so the
            // occupancy saturates at the depth.
            if (!ras_full) begin
               ras_cnt <= ras_cnt + CNT_ONE;
            end
         end else if (pop_en) begin
            wr_ptr  <= top_ptr;
            ras_cnt <= ras_cnt - CNT_ONE;
         end

         if (set_ovf) begin
            ras_ovf <= 1'b1;
         end
         if (set_unf) begin
            ras_unf <= 1'b1;
         end
      end
   end

   // Stack storage carries no reset: the cleared count makes stale
   // entries unreachable.
   always_ff @(posedge clk) begin
      if (push_en) begin
         ras_mem[wr_ptr] <= pc_inc;
      end
   end

`ifdef PCSEQ_IRQ_EN
   //------------------------------------------------------------------
   // Interrupt entry/return. The mask drops when an interrupt is taken
   // and only iret raises it again, so interrupts cannot nest.
   //------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         epc    <= '0;
         irq_en <= 1'b1;
      end else begin
         if (irq_take) begin
            epc    <= low_pc;
            irq_en <= 1'b0;
         end else if (iret_take) begin
            irq_en <= 1'b1;
         end
      end
   end

   assign irq_ack = irq_take;
`else
   // irq/iret have no effect in this build.
   logic unused_irq;
   assign unused_irq = ^{irq, iret, IRQ_VEC, irq_take, iret_take};
   assign irq_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
module tb_pc_seq_ctrl;

   localparam logic [18:0] RST_V = 19'h00000;
   localparam logic [18:0] IRQ_V = 19'h00010;

   logic        clk;
   logic        rst;
   logic [18:0] pc;
   logic        stall, halt_req, resume, br_taken, jmp, call, ret, irq, iret;
   logic [18:0] br_target, jmp_target;
   logic [18:0] pc_next;
   logic        running, irq_ack, ras_empty, ras_full, ras_ovf, ras_unf;

   pc_seq_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .pc         (pc),
      .stall      (stall),
      .halt_req   (halt_req),
      .resume     (resume),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .jmp        (jmp),
      .jmp_target (jmp_target),
      .call       (call),
      .ret        (ret),
      .irq        (irq),
      .iret       (iret),
      .pc_next    (pc_next),
      .running    (running),
      .irq_ack    (irq_ack),
      .ras_empty  (ras_empty),
      .ras_full   (ras_full),
      .ras_ovf    (ras_ovf),
      .ras_unf    (ras_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: state as a plain integer (0 boot, 1 run, 2 halt),
   // return stack as a queue whose back is the top of stack.
   int          m_state = 0;
   logic [18:0] m_ras[$];
   bit          m_ovf = 0, m_unf = 0, m_known = 0, m_mask = 1;
   logic [18:0] m_epc = '0;

   // Model predictions for the cycle being evaluated.
   logic [18:0] e_pc, e_push_val, e_epc;
   bit          e_push, e_pop, e_ovf, e_unf, e_ack, e_iret;
   int          e_state;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Where rules ret/call/jmp/br/sequential send execution, ignoring side effects.
   function automatic logic [18:0] plain_target();
      logic [18:0] inc;
      inc = pc + 19'd1;
      if (ret)           return (m_ras.size() != 0) ? m_ras[m_ras.size()-1] : inc;
      else if (call)     return jmp_target;
      else if (jmp)      return jmp_target;
      else if (br_taken) return br_target;
      return inc;
   endfunction

   task automatic model_eval();
      e_push = 0; e_pop = 0; e_ovf = 0; e_unf = 0; e_ack = 0; e_iret = 0;
      e_state = m_state;
      e_push_val = pc + 19'd1;
      e_epc = m_epc;
      if (!rst) begin
         e_pc = RST_V;
      end else if (m_state == 0) begin
         e_pc = RST_V;
         e_state = 1;
      end else if (m_state == 2) begin
         e_pc = pc;
         if (resume) e_state = 1;
      end else if (halt_req) begin
         e_pc = pc;
         e_state = 2;
      end else if (stall) begin
         e_pc = pc;
`ifdef PCSEQ_IRQ_EN
      end else if (irq && m_mask) begin
         e_pc  = IRQ_V;
         e_ack = 1;
         e_epc = plain_target();
      end else if (iret) begin
         e_pc   = m_epc;
         e_iret = 1;
`endif
      end else begin
         e_pc = plain_target();
         if (ret) begin
            if (m_ras.size() == 0) e_unf = 1;
            else                   e_pop = 1;
         end else if (call) begin
            e_push = 1;
            e_ovf  = (m_ras.size() == 8);
         end
      end
   endtask

   task automatic model_tick();
      if (!rst) begin
         m_ras.delete();
         m_state = 0; m_ovf = 0; m_unf = 0; m_mask = 1; m_epc = '0; m_known = 1;
      end else begin
         m_state = e_state;
         if (e_pop) void'(m_ras.pop_back());
         if (e_push) begin
            m_ras.push_back(e_push_val);
            if (m_ras.size() > 8) void'(m_ras.pop_front());
         end
         if (e_ovf) m_ovf = 1;
         if (e_unf) m_unf = 1;
         if (e_ack) begin m_mask = 0; m_epc = e_epc; end
         if (e_iret) m_mask = 1;
      end
   endtask

   // Mid-cycle: predict and compare every output.
   task automatic settle_check();
      @(negedge clk);
      model_eval();
      chk("pc_next", 32'(pc_next), 32'(e_pc));
      if (m_known) begin
         chk("running",   32'(running),   32'(m_state == 1));
         chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
         chk("ras_full",  32'(ras_full),  32'(m_ras.size() == 8));
         chk("ras_ovf",   32'(ras_ovf),   32'(m_ovf));
         chk("ras_unf",   32'(ras_unf),   32'(m_unf));
         chk("irq_ack",   32'(irq_ack),   32'(e_ack));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_tick();
      #1;
   endtask

   task automatic clr();
      stall = 0; halt_req = 0; resume = 0; br_taken = 0; jmp = 0;
      call = 0; ret = 0; irq = 0; iret = 0;
   endtask

   initial begin
      logic [18:0] nxt;
      rst = 0; pc = '0; br_target = '0; jmp_target = '0;
      clr();

      // Reset held for three cycles.
      for (int i = 0; i < 3; i++) begin
         settle_check();
         chk("rst_pc_next", 32'(pc_next), 32'h0);
         tick();
      end
      // BOOT cycle.
      rst = 1;
      settle_check();
      chk("boot_pc_next", 32'(pc_next), 32'h0);
      chk("boot_running", 32'(running), 32'h0);
      tick();
      pc = 19'h5;
      settle_check();
      chk("run_seq", 32'(pc_next), 32'h6);
      chk("run_running", 32'(running), 32'h1);
      tick();

      // Wrap and stall.
      pc = 19'h7FFFF;
      settle_check();
      chk("wrap", 32'(pc_next), 32'h0);
      tick();
      pc = 19'h100; stall = 1; call = 1; jmp_target = 19'h333;
      settle_check();
      chk("stall", 32'(pc_next), 32'h100);
      tick();
      clr();

      // Call then immediate return.
      pc = 19'h20; call = 1; jmp_target = 19'h400;
      settle_check();
      chk("call", 32'(pc_next), 32'h400);
      tick();
      clr(); pc = 19'h400; ret = 1;
      settle_check();
      chk("ret_zero_bubble", 32'(pc_next), 32'h21);
      tick();
      clr(); pc = 19'h21;
      settle_check();
      chk("ret_empty_after", 32'(ras_empty), 32'h1);
      tick();

      // Nine calls overflow the 8-deep stack.
      for (int i = 0; i < 9; i++) begin
         pc = 19'h10 + 19'(i); call = 1; jmp_target = 19'h200;
         settle_check();
         tick();
      end
      clr(); pc = 19'h200;
      settle_check();
      chk("ovf_flag", 32'(ras_ovf), 32'h1);
      chk("ovf_full", 32'(ras_full), 32'h1);
      tick();
      for (int i = 0; i < 8; i++) begin
         pc = 19'h300; ret = 1;
         settle_check();
         chk("ret_order", 32'(pc_next), 32'h19 - 32'(i));
         tick();
      end
      pc = 19'h300; ret = 1;
      settle_check();
      chk("unf_pc", 32'(pc_next), 32'h301);
      tick();
      clr();
      settle_check();
      chk("unf_flag", 32'(ras_unf), 32'h1);
      tick();

      // call+ret together: ret wins.
      pc = 19'h54; call = 1; jmp_target = 19'h600;
      settle_check();
      tick();
      pc = 19'h600; call = 1; ret = 1; jmp_target = 19'h700;
      settle_check();
      chk("call_ret_pri", 32'(pc_next), 32'h55);
      tick();
      clr(); pc = 19'h55;
      settle_check();
      chk("call_ret_empty", 32'(ras_empty), 32'h1);
      tick();

      // Halt ignores controls until resume.
      pc = 19'h77; halt_req = 1;
      settle_check();
      chk("halt_pc", 32'(pc_next), 32'h77);
      tick();
      clr(); jmp = 1; jmp_target = 19'h123;
      for (int i = 0; i < 3; i++) begin
         settle_check();
         chk("halt_hold", 32'(pc_next), 32'h77);
         chk("halt_running", 32'(running), 32'h0);
         tick();
      end
      resume = 1;
      settle_check();
      tick();
      clr();
      settle_check();
      chk("resumed", 32'(running), 32'h1);
      tick();

      // Randomized traffic; pc follows the model's predicted next PC.
      for (int i = 0; i < 3000; i++) begin
         rst        = ($urandom_range(0, 199) != 0);
         stall      = ($urandom_range(0, 7) == 0);
         halt_req   = ($urandom_range(0, 29) == 0);
         resume     = ($urandom_range(0, 2) == 0);
         br_taken   = ($urandom_range(0, 4) == 0);
         jmp        = ($urandom_range(0, 7) == 0);
         call       = ($urandom_range(0, 3) == 0);
         ret        = ($urandom_range(0, 4) == 0);
         irq        = ($urandom_range(0, 5) == 0);
         iret       = ($urandom_range(0, 7) == 0);
         br_target  = 19'($urandom);
         jmp_target = 19'($urandom);
         if ($urandom_range(0, 9) == 0) pc = 19'($urandom);
         settle_check();
         nxt = e_pc;
         tick();
         pc = nxt;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
